// File: rtl/execute_mdu.sv
// execute_mdu: iterative RV32M/RV64M multiply/divide execute unit.
// Optional MDU_EARLY_OUT_EN: multiplies stop once multiplier bits run out.
module execute_mdu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [RD_W-1:0] rd_idx_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_result_o,
  output logic [RD_W-1:0] resp_rd_idx_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam int DW = 2 * XLEN;
  localparam logic [XLEN-1:0] SMIN =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] CNT_INIT =
    CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;

  logic [2:0]      op_q;
  logic            b_sgn_q;
  logic            q_neg;
  logic            r_neg;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic [RD_W-1:0] rd_q;

  // request-side decode
  logic in_div;
  logic in_rem;
  logic in_sdiv;
  logic a_ms;
  logic b_ms;

  assign in_div  = op_i[2];
  assign in_rem  = op_i[1];
  assign in_sdiv = op_i[2] & ~op_i[0];
  assign a_ms    = ~op_i[2] & (op_i[1] ^ op_i[0]);
  assign b_ms    = ~op_i[2] & ~op_i[1] & op_i[0];

  logic div_zero;
  logic div_ovf;
  logic special;

  assign div_zero = rs2_data_i == '0;
  assign div_ovf  = in_sdiv
                  & (rs1_data_i == SMIN)
                  & (rs2_data_i == '1);
  assign special  = in_div & (div_zero | div_ovf);

  logic [XLEN-1:0] spec_res;

  assign spec_res = div_zero
                  ? (in_rem ? rs1_data_i : '1)
                  : (in_rem ? '0 : rs1_data_i);

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [DW-1:0]   a_ext;

  assign a_neg = in_sdiv & rs1_data_i[XLEN-1];
  assign b_neg = in_sdiv & rs2_data_i[XLEN-1];
  assign a_mag = a_neg ? -rs1_data_i : rs1_data_i;
  assign b_mag = b_neg ? -rs2_data_i : rs2_data_i;
  assign a_ext = {{XLEN{a_ms & rs1_data_i[XLEN-1]}},
                  rs1_data_i};

  // one iteration of shift-add multiply
  logic          last;
  logic [DW-1:0] mul_add;
  logic [DW-1:0] acc_nxt;

  assign last    = cnt == '0;
  assign mul_add = mplier[0] ? mcand : '0;
  // signed multiplier MSB carries weight -2^(XLEN-1)
  assign acc_nxt = (last & b_sgn_q)
                 ? acc - mul_add
                 : acc + mul_add;

  // one iteration of restoring divide
  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   diff;
  logic            r_ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign r_sh    = {rem, quo[XLEN-1]};
  assign diff    = r_sh - {1'b0, dvsr};
  assign r_ge    = ~diff[XLEN];
  assign rem_nxt = r_ge ? diff[XLEN-1:0]
                        : r_sh[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], r_ge};

  logic is_mul_lo;
  logic is_mul_hi;
  logic is_quo;
  logic is_remq;

  assign is_mul_lo = op_q == 3'b000;
  assign is_mul_hi = ~op_q[2] & (op_q[1:0] != 2'b00);
  assign is_quo    = op_q[2] & ~op_q[1];
  assign is_remq   = op_q[2] & op_q[1];

  logic [XLEN-1:0] fin_res;

  // final result select with sign restore for divides
  always_comb begin
    fin_res = '0;
    unique case (1'b1)
      is_mul_lo: fin_res = acc_nxt[XLEN-1:0];
      is_mul_hi: fin_res = acc_nxt[DW-1:XLEN];
      is_quo:    fin_res = q_neg ? -quo_nxt : quo_nxt;
      is_remq:   fin_res = r_neg ? -rem_nxt : rem_nxt;
    endcase
  end

  logic early;

`ifdef MDU_EARLY_OUT_EN
  assign early = ~op_q[2]
               & (mplier[XLEN-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  logic done_step;

  assign done_step = last | early;

  // control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready_o   <= 1'b1;
      busy_o        <= 1'b0;
      resp_valid_o  <= 1'b0;
      resp_result_o <= '0;
      resp_rd_idx_o <= '0;
      op_q          <= '0;
      b_sgn_q       <= 1'b0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      quo           <= '0;
      rem           <= '0;
      dvsr          <= '0;
      rd_q          <= '0;
    end else if (flush_i) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      resp_valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            op_q        <= op_i;
            b_sgn_q     <= b_ms;
            q_neg       <= a_neg ^ b_neg;
            r_neg       <= a_neg;
            acc         <= '0;
            mcand       <= a_ext;
            mplier      <= rs2_data_i;
            quo         <= a_mag;
            rem         <= '0;
            dvsr        <= b_mag;
            rd_q        <= rd_idx_i;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (special) begin
              resp_result_o <= spec_res;
              resp_rd_idx_o <= rd_idx_i;
              resp_valid_o  <= 1'b1;
              state         <= DONE;
            end else begin
              cnt   <= CNT_INIT;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nxt;
          quo    <= quo_nxt;
          cnt    <= done_step ? '0 : cnt - 1'b1;
          if (done_step) begin
            resp_result_o <= fin_res;
            resp_rd_idx_o <= rd_q;
            resp_valid_o  <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
          resp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: randomized and directed bench for execute_mdu.
// Reference results come from plain 64-bit arithmetic.
module tb_execute_mdu;

  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result_o;
  logic [4:0]  resp_rd_idx_o;
  logic        busy_o;

  int n_pass = 0;
  int n_total = 0;

  execute_mdu #(.XLEN(32), .RD_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .op_i          (op),
    .rs1_data_i    (rs1),
    .rs2_data_i    (rs2),
    .rd_idx_i      (rd),
    .flush_i       (flush),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result_o),
    .resp_rd_idx_o (resp_rd_idx_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(
    input logic [2:0] o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (o)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (o[2] && b == 0) return 1;
    if (o[2] && !o[0] && a == SMIN && b == 32'hFFFF_FFFF)
      return 1;
`ifdef MDU_EARLY_OUT_EN
    if (!o[2]) begin
      int k;
      k = 1;
      for (int i = 1; i < 32; i++)
        if (b[i]) k = i + 1;
      return k + 1;
    end
`endif
    return 33;
  endfunction

  // issue one request; called #1 after a rising edge
  task automatic issue(
    input  logic [2:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  r,
    input  bit          ack,
    output logic [31:0] res,
    output logic [4:0]  rdo,
    output int          lat
  );
    int w;
    w = 0;
    while (!req_ready_o && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    req_valid = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    rd = r;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid_o) lat = -1;
    res = resp_result_o;
    rdo = resp_rd_idx_o;
    if (ack) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_total++;
    if (req_ready_o !== 1'b1)
      $display("FAIL rst_ready got %b want 1", req_ready_o);
    else n_pass++;
    n_total++;
    if (resp_valid_o !== 1'b0)
      $display("FAIL rst_valid got %b want 0", resp_valid_o);
    else n_pass++;
    n_total++;
    if (busy_o !== 1'b0)
      $display("FAIL rst_busy got %b want 0", busy_o);
    else n_pass++;
    n_total++;
    if (resp_result_o !== 32'h0)
      $display("FAIL rst_result got %h want 0", resp_result_o);
    else n_pass++;
    n_total++;
    if (resp_rd_idx_o !== 5'h0)
      $display("FAIL rst_rd got %h want 0", resp_rd_idx_o);
    else n_pass++;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b010,
                             3'b011, 3'b000};
    logic [31:0] av  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_1234};
    logic [31:0] bv  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_0001};
    logic [31:0] ev  [5] = '{32'h0000_0001, 32'h0000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFE,
                             32'h0000_1234};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat, el;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], av[i], bv[i], 5'(i + 1), 1'b1,
            res, rdo, lat);
      el = ref_lat(ops[i], av[i], bv[i]);
      n_total++;
      if (res !== ev[i])
        $display("FAIL mul_res[%0d] got %h want %h",
                 i, res, ev[i]);
      else n_pass++;
      n_total++;
      if (rdo !== 5'(i + 1))
        $display("FAIL mul_rd[%0d] got %0d want %0d",
                 i, rdo, i + 1);
      else n_pass++;
      n_total++;
      if (lat != el)
        $display("FAIL mul_lat[%0d] got %0d want %0d",
                 i, lat, el);
      else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd7, 32'd7};
    logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd3, 32'd1};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], 32'd2, 5'(i + 10), 1'b1,
            res, rdo, lat);
      n_total++;
      if (res !== ev[i])
        $display("FAIL div_res[%0d] got %h want %h",
                 i, res, ev[i]);
      else n_pass++;
      n_total++;
      if (rdo !== 5'(i + 10))
        $display("FAIL div_rd[%0d] got %0d want %0d",
                 i, rdo, i + 10);
      else n_pass++;
      n_total++;
      if (lat != 33)
        $display("FAIL div_lat[%0d] got %0d want 33",
                 i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [6] = '{3'b101, 3'b110, 3'b100,
                             3'b110, 3'b100, 3'b111};
    logic [31:0] av  [6] = '{32'd5, 32'd5, SMIN,
                             SMIN, 32'd5, 32'd9};
    logic [31:0] bv  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] ev  [6] = '{32'hFFFF_FFFF, 32'd5, SMIN,
                             32'd0, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], av[i], bv[i], 5'(i + 20), 1'b1,
            res, rdo, lat);
      n_total++;
      if (res !== ev[i])
        $display("FAIL spc_res[%0d] got %h want %h",
                 i, res, ev[i]);
      else n_pass++;
      n_total++;
      if (rdo !== 5'(i + 20))
        $display("FAIL spc_rd[%0d] got %0d want %0d",
                 i, rdo, i + 20);
      else n_pass++;
      n_total++;
      if (lat != 1)
        $display("FAIL spc_lat[%0d] got %0d want 1",
                 i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, res, er;
    logic [4:0]  r, rdo;
    int          lat, el, sel;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      r = 5'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 0;
      if (sel == 1) begin a = SMIN; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(0, 3));
      if (sel == 3) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      issue(o, a, b, r, 1'b1, res, rdo, lat);
      er = ref_res(o, a, b);
      el = ref_lat(o, a, b);
      n_total++;
      if (res !== er)
        $display("FAIL rnd_res op=%0d a=%h b=%h got %h want %h",
                 o, a, b, res, er);
      else n_pass++;
      n_total++;
      if (rdo !== r)
        $display("FAIL rnd_rd got %0d want %0d", rdo, r);
      else n_pass++;
      n_total++;
      if (lat != el)
        $display("FAIL rnd_lat op=%0d b=%h got %0d want %0d",
                 o, b, lat, el);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    bit seen;
    req_valid = 1'b1;
    op = 3'b100;
    rs1 = 32'd1000;
    rs2 = 32'd7;
    rd = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_total++;
    if (busy_o !== 1'b1)
      $display("FAIL flush_busy_pre got %b want 1", busy_o);
    else n_pass++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_total++;
    if (busy_o !== 1'b0 || req_ready_o !== 1'b1)
      $display("FAIL flush_idle got busy=%b rdy=%b want 0/1",
               busy_o, req_ready_o);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid_o) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0)
      $display("FAIL flush_noresp got %b want 0", seen);
    else n_pass++;
    req_valid = 1'b1;
    flush = 1'b1;
    op = 3'b101;
    rs1 = 32'd5;
    rs2 = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush = 1'b0;
    n_total++;
    if (busy_o !== 1'b0 || resp_valid_o !== 1'b0)
      $display("FAIL flush_drop got busy=%b vld=%b want 0/0",
               busy_o, resp_valid_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17,
          1'b0, res, rdo, lat);
    req_valid = 1'b1;
    op = 3'b000;
    rs1 = 32'd3;
    rs2 = 32'd3;
    rd = 5'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0)
        $display("FAIL bp_hs[%0d] got vld=%b rdy=%b want 1/0",
                 i, resp_valid_o, req_ready_o);
      else n_pass++;
      n_total++;
      if (resp_result_o !== 32'h0FD5_BDEE)
        $display("FAIL bp_res[%0d] got %h want 0fd5bdee",
                 i, resp_result_o);
      else n_pass++;
      n_total++;
      if (resp_rd_idx_o !== 5'd17)
        $display("FAIL bp_rd[%0d] got %0d want 17",
                 i, resp_rd_idx_o);
      else n_pass++;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_total++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1)
      $display("FAIL bp_release got vld=%b rdy=%b want 0/1",
               resp_valid_o, req_ready_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    issue(3'b111, 32'd100, 32'd0, 5'd1, 1'b1,
          res, rdo, lat);
    n_total++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL b2b_gap got rdy=%b busy=%b want 1/0",
               req_ready_o, busy_o);
    else n_pass++;
    issue(3'b101, 32'd100, 32'd0, 5'd2, 1'b1,
          res, rdo, lat);
    n_total++;
    if (res !== 32'hFFFF_FFFF || rdo !== 5'd2 || lat != 1)
      $display("FAIL b2b_second got %h/%0d/%0d want ffffffff/2/1",
               res, rdo, lat);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    req_valid = 1'b1;
    op = 3'b000;
    rs1 = 32'd77;
    rs2 = 32'h8000_0001;
    rd = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (busy_o !== 1'b0 || resp_valid_o !== 1'b0 ||
        req_ready_o !== 1'b1)
      $display("FAIL arst_calc got busy=%b vld=%b rdy=%b",
               busy_o, resp_valid_o, req_ready_o);
    else n_pass++;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'b001, 32'h7000_0000, 32'h7000_0000, 5'd30,
          1'b0, res, rdo, lat);
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (resp_valid_o !== 1'b0 || resp_result_o !== 32'h0 ||
        resp_rd_idx_o !== 5'd0)
      $display("FAIL arst_done got vld=%b res=%h rd=%0d",
               resp_valid_o, resp_result_o, resp_rd_idx_o);
    else n_pass++;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d",
             n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
